move_validator: RTL and testbench

- Full-move legality checker for the Othello engine. Given an origin square and the player to move, it walks all 8 directions through board RAM with explicit row/column bounds, so a walk never wraps across a board edge.
- Reports which directions capture, the total number of discs to flip, and an overall legal flag.
- Successor to the single-direction walker: parametrised board size, built-in direction sequencing, flip counting and an early-exit "any legal" mode.
- Sits between the move controller and the board RAM; the flipper consumes dir_mask.

---
 rtl/othello_pkg.sv | 33 +++
 rtl/pos_stepper.sv | 32 +++
 rtl/move_validator.sv | 204 ++++++++++++++++++++
 tb/tb_move_validator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/othello_pkg.sv
// Shared Othello definitions: cell encoding, direction delta tables, validator FSM states.
// Cell-colour helpers keep the player-to-colour mapping in one place.
package othello_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;
  localparam logic [1:0] CELL_INV   = 2'b11;

  // Deltas as 2-bit two's complement (2'b11 = -1), order N, NE, E, SE, S, SW, W, NW.
  localparam logic [1:0] DROW [8] = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11};
  localparam logic [1:0] DCOL [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b11};

  typedef enum logic [2:0] {
    IDLE,
    ORIG_RD,
    ORIG_CHK,
    DIR_SETUP,
    PROBE_RD,
    PROBE_CHK,
    DIR_NEXT,
    FINISH
  } state_t;

  function automatic logic [1:0] own_of(input logic player);
    return player ? CELL_WHITE : CELL_BLACK;
  endfunction

  function automatic logic [1:0] opp_of(input logic player);
    return player ? CELL_BLACK : CELL_WHITE;
  endfunction

endpackage

// File: rtl/pos_stepper.sv
// One-square step from (row, col) in direction dir, with board-edge detection.
// Shared by the move validator and the flipper.
module pos_stepper
  import othello_pkg::*;
#(
  parameter int BOARD_N = 8,
  parameter int IDX_W   = $clog2(BOARD_N)
) (
  input  logic [IDX_W-1:0] row,
  input  logic [IDX_W-1:0] col,
  input  logic [2:0]       dir,
  output logic [IDX_W-1:0] next_row,
  output logic [IDX_W-1:0] next_col,
  output logic             in_bounds
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(BOARD_N);

  logic [IDX_W:0] r_s;
  logic [IDX_W:0] c_s;

  // A step to -1 wraps to a large unsigned value, so one compare against
  // BOARD_N rejects both edges without ever forming a wrapped address.
  always_comb begin
    r_s       = {1'b0, row} + {{(IDX_W-1){DROW[dir][1]}}, DROW[dir]};
    c_s       = {1'b0, col} + {{(IDX_W-1){DCOL[dir][1]}}, DCOL[dir]};
    in_bounds = (r_s < N_EXT) && (c_s < N_EXT);
    next_row  = r_s[IDX_W-1:0];
    next_col  = c_s[IDX_W-1:0];
  end

endmodule

// File: rtl/move_validator.sv
// Full-move legality checker: walks all 8 directions from an empty origin and
// reports capturing directions, total flips and an overall legal flag.
module move_validator
  import othello_pkg::*;
#(
  parameter int BOARD_N = 8,
  parameter int IDX_W   = $clog2(BOARD_N),
  parameter int ADDR_W  = $clog2(BOARD_N*BOARD_N),
  parameter int CNT_W   = $clog2(8*(BOARD_N-2)+1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              player,
  input  logic              find_any,
  input  logic [IDX_W-1:0]  row_in,
  input  logic [IDX_W-1:0]  col_in,
  output logic              busy,
  output logic              done,
  output logic              legal,
  output logic [7:0]        dir_mask,
  output logic [CNT_W-1:0]  flip_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  input  logic [1:0]        mem_data,
  output state_t            state_dbg
);

  // Handshake: start is taken only in IDLE (ignored otherwise); busy rises the
  // cycle after acceptance; done pulses one cycle as busy falls; results hold
  // until the next accepted start. mem_data answers a mem_rden one cycle later.

  state_t             state, state_d;
  logic [2:0]         dir, dir_d;
  logic [IDX_W-1:0]   org_row, org_row_d, org_col, org_col_d;
  logic [IDX_W-1:0]   pos_row, pos_row_d, pos_col, pos_col_d;
  logic [CNT_W-1:0]   run, run_d;
  logic               player_q, player_d;
  logic               find_any_q, find_any_d;
  logic               busy_d, done_d, legal_d, mem_rden_d;
  logic [7:0]         dir_mask_d;
  logic [CNT_W-1:0]   flip_count_d;
  logic [ADDR_W-1:0]  mem_addr_d;

  logic [IDX_W-1:0]   step_row, step_col, nxt_row, nxt_col;
  logic               nxt_in;
  logic [1:0]         own_cell, opp_cell;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] r,
                                                input logic [IDX_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(BOARD_N) + ADDR_W'(c);
  endfunction

  // DIR_SETUP steps from the origin; PROBE_CHK steps from the current probe.
  assign step_row  = (state == DIR_SETUP) ? org_row : pos_row;
  assign step_col  = (state == DIR_SETUP) ? org_col : pos_col;
  assign own_cell  = own_of(player_q);
  assign opp_cell  = opp_of(player_q);
  assign state_dbg = state;

  pos_stepper #(.BOARD_N(BOARD_N), .IDX_W(IDX_W)) u_step (
    .row       (step_row),
    .col       (step_col),
    .dir       (dir),
    .next_row  (nxt_row),
    .next_col  (nxt_col),
    .in_bounds (nxt_in)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dir        <= '0;
      org_row    <= '0;
      org_col    <= '0;
      pos_row    <= '0;
      pos_col    <= '0;
      run        <= '0;
      player_q   <= 1'b0;
      find_any_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      legal      <= 1'b0;
      dir_mask   <= '0;
      flip_count <= '0;
      mem_addr   <= '0;
      mem_rden   <= 1'b0;
    end else begin
      state      <= state_d;
      dir        <= dir_d;
      org_row    <= org_row_d;
      org_col    <= org_col_d;
      pos_row    <= pos_row_d;
      pos_col    <= pos_col_d;
      run        <= run_d;
      player_q   <= player_d;
      find_any_q <= find_any_d;
      busy       <= busy_d;
      done       <= done_d;
      legal      <= legal_d;
      dir_mask   <= dir_mask_d;
      flip_count <= flip_count_d;
      mem_addr   <= mem_addr_d;
      mem_rden   <= mem_rden_d;
    end
  end

  always_comb begin
    state_d      = state;
    dir_d        = dir;
    org_row_d    = org_row;
    org_col_d    = org_col;
    pos_row_d    = pos_row;
    pos_col_d    = pos_col;
    run_d        = run;
    player_d     = player_q;
    find_any_d   = find_any_q;
    busy_d       = busy;
    done_d       = 1'b0;
    legal_d      = legal;
    dir_mask_d   = dir_mask;
    flip_count_d = flip_count;
    mem_addr_d   = mem_addr;
    mem_rden_d   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          org_row_d    = row_in;
          org_col_d    = col_in;
          player_d     = player;
          find_any_d   = find_any;
          dir_mask_d   = '0;
          flip_count_d = '0;
          legal_d      = 1'b0;
          busy_d       = 1'b1;
          mem_addr_d   = addr_of(row_in, col_in);
          mem_rden_d   = 1'b1;
          state_d      = ORIG_RD;
        end
      end
      ORIG_RD: state_d = ORIG_CHK;
      ORIG_CHK: begin
        if (mem_data != CELL_EMPTY) begin
          state_d = FINISH;
        end else begin
          dir_d   = 3'd0;
          state_d = DIR_SETUP;
        end
      end
      DIR_SETUP: begin
        run_d = '0;
        if (nxt_in) begin
          pos_row_d  = nxt_row;
          pos_col_d  = nxt_col;
          mem_addr_d = addr_of(nxt_row, nxt_col);
          mem_rden_d = 1'b1;
          state_d    = PROBE_RD;
        end else begin
          state_d = DIR_NEXT;
        end
      end
      PROBE_RD: state_d = PROBE_CHK;
      PROBE_CHK: begin
        state_d = DIR_NEXT;
        case (mem_data)
          CELL_BLACK, CELL_WHITE: begin
            if (mem_data == opp_cell) begin
              run_d = run + CNT_W'(1);
              if (nxt_in) begin
                pos_row_d  = nxt_row;
                pos_col_d  = nxt_col;
                mem_addr_d = addr_of(nxt_row, nxt_col);
                mem_rden_d = 1'b1;
                state_d    = PROBE_RD;
              end
            end else if (mem_data == own_cell && run != '0) begin
              dir_mask_d[dir] = 1'b1;
              flip_count_d    = flip_count + run;
              legal_d         = 1'b1;
            end
          end
          CELL_EMPTY, CELL_INV: state_d = DIR_NEXT;
          default: state_d = DIR_NEXT;
        endcase
      end
      DIR_NEXT: begin
        if (dir == 3'd7 || (find_any_q && legal)) begin
          state_d = FINISH;
        end else begin
          dir_d   = dir + 3'd1;
          state_d = DIR_SETUP;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_move_validator.sv
// Directed and randomized bench for move_validator on an 8x8 board, checked
// against a direction-walking reference model and an expected read-address queue.
module tb_move_validator;
  import othello_pkg::*;

  localparam int N      = 8;
  localparam int IDX_W  = 3;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = 6;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              player = 1'b0;
  logic              find_any = 1'b0;
  logic [IDX_W-1:0]  row_in = '0;
  logic [IDX_W-1:0]  col_in = '0;
  logic              busy, done, legal, mem_rden;
  logic [7:0]        dir_mask;
  logic [CNT_W-1:0]  flip_count;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_data = 2'b00;
  state_t            state_dbg;

  logic [1:0]        board [N*N];
  logic [ADDR_W-1:0] exp_q [$];
  int                compared = 0;
  int                mismatched = 0;

  // clock / reset
  always #5 clock = ~clock;

  move_validator #(.BOARD_N(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .player     (player),
    .find_any   (find_any),
    .row_in     (row_in),
    .col_in     (col_in),
    .busy       (busy),
    .done       (done),
    .legal      (legal),
    .dir_mask   (dir_mask),
    .flip_count (flip_count),
    .mem_addr   (mem_addr),
    .mem_rden   (mem_rden),
    .mem_data   (mem_data),
    .state_dbg  (state_dbg)
  );

  // board RAM: one-cycle read latency
  always @(posedge clock) if (mem_rden) mem_data <= board[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every read strobe must match the next expected address
  always @(negedge clock) begin
    if (reset === 1'b1 && mem_rden === 1'b1) begin
      logic [31:0] exp_a;
      exp_a = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
      check("read_addr", 32'(mem_addr), exp_a);
    end
  end

  task automatic clear_board();
    for (int i = 0; i < N*N; i++) board[i] = CELL_EMPTY;
  endtask

  task automatic opening();
    clear_board();
    board[3*N+3] = CELL_WHITE; board[3*N+4] = CELL_BLACK;
    board[4*N+3] = CELL_BLACK; board[4*N+4] = CELL_WHITE;
  endtask

  // reference model: walk each direction from the rules, queue the reads it implies
  task automatic model(input int r, input int c, input logic p, input logic fa,
                       output logic [7:0] m, output int cnt, output int lat);
    int dr [8];
    int dc [8];
    logic [1:0] own, opp;
    dr  = '{-1, -1, 0, 1, 1, 1, 0, -1};
    dc  = '{0, 1, 1, 1, 0, -1, -1, -1};
    own = p ? 2'b10 : 2'b01;
    opp = p ? 2'b01 : 2'b10;
    m = 8'h00; cnt = 0; lat = 4;
    exp_q.push_back(ADDR_W'(r*N + c));
    if (board[r*N + c] != 2'b00) return;
    for (int d = 0; d < 8; d++) begin
      int rr, cc, run;
      lat += 2;
      rr = r + dr[d]; cc = c + dc[d]; run = 0;
      while (rr >= 0 && rr < N && cc >= 0 && cc < N) begin
        exp_q.push_back(ADDR_W'(rr*N + cc));
        lat += 2;
        if (board[rr*N + cc] == opp) begin
          run++; rr += dr[d]; cc += dc[d];
        end else begin
          if (board[rr*N + cc] == own && run > 0) begin
            m[d] = 1'b1; cnt += run;
          end
          break;
        end
      end
      if (fa && m != 8'h00) break;
    end
  endtask

  // driver: one move, compared against the model; optional start pulse while busy
  task automatic do_move(input string tag, input int r, input int c, input logic p,
                         input logic fa, input logic pulse,
                         output logic [7:0] gm, output int gc, output logic gl, output int k);
    logic [7:0] em;
    int ec, el;
    model(r, c, p, fa, em, ec, el);
    @(negedge clock);
    start = 1'b1; player = p; find_any = fa; row_in = IDX_W'(r); col_in = IDX_W'(c);
    @(posedge clock);
    #1 start = 1'b0; player = ~p; find_any = ~fa; row_in = ~row_in; col_in = ~col_in;
    k = 0;
    while (k < 2000) begin
      @(negedge clock);
      k++;
      if (k == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (pulse && k == 2) begin start = 1'b1; row_in = '0; col_in = '0; end
      if (k == 3) start = 1'b0;
      if (done === 1'b1) break;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(k), 32'(el));
    check({tag, "_legal"}, 32'(legal), 32'(em != 8'h00));
    check({tag, "_mask"}, 32'(dir_mask), 32'(em));
    check({tag, "_count"}, 32'(flip_count), 32'(ec));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    gm = dir_mask; gc = int'(flip_count); gl = legal;
    @(negedge clock);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_mask_hold"}, 32'(dir_mask), 32'(em));
    check({tag, "_reads_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] gm;
    int gc, k, k0, k1, tries;
    logic gl;

    clear_board();
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_legal", 32'(legal), 32'd0);
    check("rst_mask", 32'(dir_mask), 32'd0);
    check("rst_rden", 32'(mem_rden), 32'd0);
    @(negedge clock) reset = 1'b1;

    opening();
    do_move("open_23", 2, 3, 1'b0, 1'b0, 1'b0, gm, gc, gl, k);
    check("open_23_mask_lit", 32'(gm), 32'h10);
    check("open_23_cnt_lit", 32'(gc), 32'd1);
    check("open_23_legal_lit", 32'(gl), 32'd1);

    do_move("open_22", 2, 2, 1'b0, 1'b0, 1'b0, gm, gc, gl, k);
    check("open_22_mask_lit", 32'(gm), 32'h00);
    check("open_22_legal_lit", 32'(gl), 32'd0);

    do_move("occupied", 3, 3, 1'b0, 1'b0, 1'b0, gm, gc, gl, k);
    check("occupied_lat_lit", 32'(k), 32'd4);
    check("occupied_legal_lit", 32'(gl), 32'd0);

    clear_board();
    for (int i = 1; i < N; i++) board[i] = CELL_WHITE;
    board[1*N+0] = CELL_BLACK;
    do_move("edge", 0, 0, 1'b0, 1'b0, 1'b0, gm, gc, gl, k);
    check("edge_e_bit", 32'(gm[2]), 32'd0);
    check("edge_legal_lit", 32'(gl), 32'd0);

    clear_board();
    board[3*N+4] = CELL_WHITE; board[2*N+4] = CELL_WHITE; board[1*N+4] = CELL_BLACK;
    board[5*N+4] = CELL_WHITE; board[6*N+4] = CELL_BLACK;
    do_move("two_dir", 4, 4, 1'b0, 1'b0, 1'b0, gm, gc, gl, k0);
    check("two_dir_mask_lit", 32'(gm), 32'h11);
    check("two_dir_cnt_lit", 32'(gc), 32'd3);
    do_move("two_any", 4, 4, 1'b0, 1'b1, 1'b0, gm, gc, gl, k1);
    check("two_any_mask_lit", 32'(gm), 32'h01);
    check("two_any_cnt_lit", 32'(gc), 32'd2);
    check("two_any_earlier", 32'(k1 < k0), 32'd1);

    // reset in the middle of a walk
    opening();
    model(2, 2, 1'b0, 1'b0, gm, gc, k);
    @(negedge clock);
    start = 1'b1; player = 1'b0; find_any = 1'b0; row_in = 3'd2; col_in = 3'd2;
    @(posedge clock);
    #1 start = 1'b0;
    tries = 0;
    while (tries < 200 && state_dbg != PROBE_CHK) begin
      @(negedge clock);
      tries++;
    end
    check("rst_mid_reached", 32'(state_dbg == PROBE_CHK), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_legal", 32'(legal), 32'd0);
    check("rst_mid_mask", 32'(dir_mask), 32'd0);
    check("rst_mid_count", 32'(flip_count), 32'd0);
    check("rst_mid_addr", 32'(mem_addr), 32'd0);
    check("rst_mid_rden", 32'(mem_rden), 32'd0);
    exp_q.delete();
    @(negedge clock) reset = 1'b1;
    do_move("after_rst", 2, 3, 1'b0, 1'b0, 1'b1, gm, gc, gl, k);
    check("after_rst_mask_lit", 32'(gm), 32'h10);

    // randomized boards and moves
    for (int t = 0; t < 40; t++) begin
      int r, c, v;
      for (int i = 0; i < N*N; i++) begin
        v = $urandom_range(0, 9);
        board[i] = (v < 4) ? CELL_EMPTY : (v < 7) ? CELL_BLACK : (v < 9) ? CELL_WHITE : CELL_INV;
      end
      r = $urandom_range(0, N-1);
      c = $urandom_range(0, N-1);
      if ($urandom_range(0, 3) != 0) board[r*N + c] = CELL_EMPTY;
      do_move("rand", r, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), gm, gc, gl, k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
